// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues and retries requests against a
// stallable multi-cycle memory, freezes the pipeline while an access is open.
module dmem_access_ctrl #(
    parameter int TIMEOUT     = 64,
    parameter int ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_valid,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrt,
    input  logic [15:0] MEM_Addr,
    input  logic [15:0] MEM_WriteData,
    output logic        mem_Rd,
    output logic        mem_Wr,
    output logic [15:0] mem_Addr,
    output logic [15:0] mem_DataIn,
    input  logic        mem_Stall,
    input  logic        mem_Done,
    input  logic [15:0] mem_DataOut,
    input  logic        mem_err,
    output logic        Done_DM,
    output logic [15:0] MEM_readData,
    output logic        MMEM_err,
    output logic        stall_pipe,
    output logic [15:0] stall_cycles
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        rd_q, rd_nxt;
    logic [15:0] rdata_q;
    logic        capture;
    logic        access, illegal, misal;

    assign access  = MEM_valid & (MEM_MemRead ^ MEM_MemWrt);
    assign illegal = MEM_valid & MEM_MemRead & MEM_MemWrt;
    assign misal   = access & (ALIGN_CHECK != 0) & MEM_Addr[0];

    // Address and data are held by the frozen pipeline, so no capture needed.
    assign mem_Addr   = MEM_Addr;
    assign mem_DataIn = MEM_WriteData;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rd_nxt       = rd_q;
        mem_Rd       = 1'b0;
        mem_Wr       = 1'b0;
        Done_DM      = 1'b1;
        stall_pipe   = 1'b0;
        MMEM_err     = 1'b0;
        MEM_readData = rdata_q;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (illegal || misal) begin
                    MMEM_err = 1'b1;
                end else if (access) begin
                    mem_Rd = MEM_MemRead;
                    mem_Wr = MEM_MemWrt;
                    if (mem_Stall) begin
                        stall_pipe = 1'b1;
                        Done_DM    = 1'b0;
                    end else if (mem_Done) begin
                        MMEM_err     = mem_err;
                        MEM_readData = MEM_MemRead ? mem_DataOut : 16'h0;
                        capture      = 1'b1;
                    end else begin
                        stall_pipe = 1'b1;
                        Done_DM    = 1'b0;
                        cnt_nxt    = 8'd1;
                        rd_nxt     = MEM_MemRead;
                        state_nxt  = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mem_Done) begin
                    MMEM_err     = mem_err;
                    MEM_readData = rd_q ? mem_DataOut : 16'h0;
                    capture      = 1'b1;
                    state_nxt    = IDLE;
                end else if (cnt == CNT_LAST) begin
                    MMEM_err     = 1'b1;
                    MEM_readData = 16'h0;
                    state_nxt    = IDLE;
                end else begin
                    stall_pipe = 1'b1;
                    Done_DM    = 1'b0;
                    cnt_nxt    = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            rd_q         <= 1'b0;
            rdata_q      <= 16'h0;
            stall_cycles <= 16'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rd_q  <= rd_nxt;
            if (capture)
                rdata_q <= mem_DataOut;
            if (stall_pipe && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus scripted random
// accesses judged against a per-instruction latency model.
module tb_dmem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_valid, MEM_MemRead, MEM_MemWrt;
    logic [15:0] MEM_Addr, MEM_WriteData;
    logic        mem_Rd, mem_Wr;
    logic [15:0] mem_Addr, mem_DataIn;
    logic        mem_Stall, mem_Done, mem_err;
    logic [15:0] mem_DataOut;
    logic        Done_DM, MMEM_err, stall_pipe;
    logic [15:0] MEM_readData, stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_stalls = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT(TO), .ALIGN_CHECK(1)) dut (
        .clk(clk), .rst(rst),
        .MEM_valid(MEM_valid), .MEM_MemRead(MEM_MemRead), .MEM_MemWrt(MEM_MemWrt),
        .MEM_Addr(MEM_Addr), .MEM_WriteData(MEM_WriteData),
        .mem_Rd(mem_Rd), .mem_Wr(mem_Wr), .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn),
        .mem_Stall(mem_Stall), .mem_Done(mem_Done), .mem_DataOut(mem_DataOut),
        .mem_err(mem_err),
        .Done_DM(Done_DM), .MEM_readData(MEM_readData), .MMEM_err(MMEM_err),
        .stall_pipe(stall_pipe), .stall_cycles(stall_cycles)
    );

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        MEM_valid = v; MEM_MemRead = r; MEM_MemWrt = w;
        MEM_Addr = a; MEM_WriteData = d;
    endtask

    task automatic mem(input logic st, input logic dn, input logic [15:0] dout, input logic e);
        mem_Stall = st; mem_Done = dn; mem_DataOut = dout; mem_err = e;
    endtask

    // Flags checked each cycle: {mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err}
    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 16'h0, 16'h0);
        mem(0, 0, 16'h0, 0);
        tick(); tick();
        rst = 1'b0;
        drive(1, 0, 0, 16'h1234, 16'h5678);
        #1;
        n_tests++;
        if ({mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err} !== 5'b00100 ||
            MEM_readData !== 16'h0 || stall_cycles !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_idle: flags=%b rdata=%h stalls=%0d want flags=00100 rdata=0000 stalls=0",
                     {mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err}, MEM_readData, stall_cycles);
        end
        tick();
    endtask

    task automatic test_hit_load();
        drive(1, 1, 0, 16'h0040, 16'h0);
        mem(0, 1, 16'hBEEF, 0);
        #1;
        n_tests++;
        if ({mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err} !== 5'b10100 ||
            MEM_readData !== 16'hBEEF || mem_Addr !== 16'h0040) begin
            n_fail++;
            $display("FAIL hit_load: flags=%b rdata=%h addr=%h want flags=10100 rdata=beef addr=0040",
                     {mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err}, MEM_readData, mem_Addr);
        end
        tick();
        drive(1, 0, 0, 16'h0, 16'h0);
        mem(0, 0, 16'h0, 0);
        #1;
        n_tests++;
        if ({mem_Rd, mem_Wr, Done_DM, stall_pipe} !== 4'b0010 || stall_cycles !== 16'(exp_stalls)) begin
            n_fail++;
            $display("FAIL hit_after: flags=%b stalls=%0d want 0010 stalls=%0d",
                     {mem_Rd, mem_Wr, Done_DM, stall_pipe}, stall_cycles, exp_stalls);
        end
        tick();
    endtask

    // Done arrives on the cycle where the wait counter equals TIMEOUT-1, so
    // this also covers done-over-timeout priority.
    task automatic test_miss_store();
        drive(1, 0, 1, 16'h0102, 16'h1234);
        mem(0, 0, 16'h0, 0);
        for (int c = 0; c < 4; c++) begin
            logic [4:0] want;
            mem(0, (c == 3), 16'hAAAA, 0);
            want = (c == 0) ? 5'b01010 : (c == 3) ? 5'b00100 : 5'b00010;
            #1;
            n_tests++;
            if ({mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err} !== want ||
                (c == 0 && mem_DataIn !== 16'h1234) || (c == 3 && MEM_readData !== 16'h0)) begin
                n_fail++;
                $display("FAIL miss_store c%0d: flags=%b din=%h rdata=%h want flags=%b din=1234",
                         c, {mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err}, mem_DataIn, MEM_readData, want);
            end
            tick();
        end
        exp_stalls += 3;
        drive(1, 0, 0, 16'h0, 16'h0);
        mem(0, 0, 16'h0, 0);
        #1;
        n_tests++;
        if (stall_cycles !== 16'(exp_stalls)) begin
            n_fail++;
            $display("FAIL miss_store_count: stalls=%0d want %0d", stall_cycles, exp_stalls);
        end
        tick();
    endtask

    task automatic test_stall_then_hit();
        drive(1, 1, 0, 16'h0044, 16'h0);
        for (int c = 0; c < 3; c++) begin
            logic [4:0] want;
            if (c < 2) mem(1, 0, 16'h0, 0);
            else       mem(0, 1, 16'hCAFE, 0);
            want = (c < 2) ? 5'b10010 : 5'b10100;
            #1;
            n_tests++;
            if ({mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err} !== want ||
                (c == 2 && MEM_readData !== 16'hCAFE)) begin
                n_fail++;
                $display("FAIL stall_hit c%0d: flags=%b rdata=%h want flags=%b rdata=cafe",
                         c, {mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err}, MEM_readData, want);
            end
            tick();
        end
        exp_stalls += 2;
    endtask

    task automatic test_misaligned_illegal();
        logic [15:0] addrs [4] = '{16'h0041, 16'h0041, 16'h0040, 16'h0060};
        logic        rds   [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic        wrs   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [4:0]  wants [4] = '{5'b00101, 5'b00101, 5'b00101, 5'b10101};
        for (int i = 0; i < 4; i++) begin
            drive(1, rds[i], wrs[i], addrs[i], 16'h0);
            // Last entry is an aligned hit that reports a memory error.
            mem(0, (i == 3), 16'h0101, (i == 3));
            #1;
            n_tests++;
            if ({mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err} !== wants[i]) begin
                n_fail++;
                $display("FAIL err_case%0d: flags=%b want %b",
                         i, {mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err}, wants[i]);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        drive(1, 1, 0, 16'h0010, 16'h0);
        for (int c = 0; c < 4; c++) begin
            logic [4:0] want;
            mem(0, 0, 16'hFFFF, 0);
            want = (c == 0) ? 5'b10010 : (c == 3) ? 5'b00101 : 5'b00010;
            #1;
            n_tests++;
            if ({mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err} !== want ||
                (c == 3 && MEM_readData !== 16'h0)) begin
                n_fail++;
                $display("FAIL timeout c%0d: flags=%b rdata=%h want flags=%b rdata=0000",
                         c, {mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err}, MEM_readData, want);
            end
            tick();
        end
        exp_stalls += TO - 1;
        drive(1, 0, 0, 16'h0, 16'h0);
        mem(0, 1, 16'h7777, 1);
        #1;
        n_tests++;
        if ({mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err} !== 5'b00100 ||
            stall_cycles !== 16'(exp_stalls)) begin
            n_fail++;
            $display("FAIL stray_done: flags=%b stalls=%0d want 00100 stalls=%0d",
                     {mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err}, stall_cycles, exp_stalls);
        end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        drive(1, 1, 0, 16'h0020, 16'h0);
        mem(0, 0, 16'h0, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 0, 0, 16'h0020, 16'h0);
        #1;
        exp_stalls = 0;
        n_tests++;
        if ({mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err} !== 5'b00100 ||
            MEM_readData !== 16'h0 || stall_cycles !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_busy: flags=%b rdata=%h stalls=%0d want 00100 0000 0",
                     {mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err}, MEM_readData, stall_cycles);
        end
        tick();
    endtask

    // Each instruction gets a script: s refusal cycles, then done n cycles
    // after acceptance (n=0 hit, n>=TO never within the timeout window).
    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            logic        v, r, w, e, acc, ill, mis;
            logic [15:0] a, d, dout;
            int          s, n, k;
            v = ($urandom_range(0, 7) != 0);
            r = $urandom_range(0, 1);
            w = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) begin r = 1'b1; w = 1'b1; end
            a = 16'($urandom) & ~16'h1;
            if ($urandom_range(0, 4) == 0) a[0] = 1'b1;
            d = 16'($urandom); dout = 16'($urandom);
            e = ($urandom_range(0, 5) == 0);
            s = $urandom_range(0, 2);
            n = $urandom_range(0, 6);
            acc = v && (r != w);
            ill = v && r && w;
            mis = acc && a[0];

            drive(v, r, w, a, d);
            #1;
            n_tests++;
            if (stall_cycles !== 16'(exp_stalls)) begin
                n_fail++;
                $display("FAIL rnd%0d_count: stalls=%0d want %0d", i, stall_cycles, exp_stalls);
            end
            #1;
            if (!acc || ill || mis) begin
                mem(1'($urandom), 1'($urandom), dout, 1'($urandom));
                #1;
                n_tests++;
                if ({mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err} !== {4'b0010, ill || mis}) begin
                    n_fail++;
                    $display("FAIL rnd%0d_noacc: flags=%b want %b", i,
                             {mem_Rd, mem_Wr, Done_DM, stall_pipe, MMEM_err}, {4'b0010, ill || mis});
                end
                tick();
                continue;
            end
            for (int c = 0; c < s; c++) begin
                mem(1, 0, 16'($urandom), 0);
                #1;
                n_tests++;
                if ({mem_Rd, mem_Wr, Done_DM, stall_pipe} !== {r, w, 2'b01}) begin
                    n_fail++;
                    $display("FAIL rnd%0d_refused: flags=%b want %b", i,
                             {mem_Rd, mem_Wr, Done_DM, stall_pipe}, {r, w, 2'b01});
                end
                exp_stalls++;
                tick();
            end
            k = 0;
            forever begin
                logic fin, terr;
                logic [15:0] trd;
                mem(0, (k == n), (k == n) ? dout : 16'($urandom), e);
                fin  = (k == n) || (k == TO - 1);
                terr = (k == n) ? e : 1'b1;
                trd  = (k == n && r) ? dout : 16'h0;
                #1;
                n_tests++;
                if ({mem_Rd, mem_Wr, Done_DM, stall_pipe} !== {(k == 0) & r, (k == 0) & w, fin, !fin} ||
                    (fin && (MMEM_err !== terr || MEM_readData !== trd))) begin
                    n_fail++;
                    $display("FAIL rnd%0d_k%0d: flags=%b err=%b rdata=%h want %b err=%b rdata=%h",
                             i, k, {mem_Rd, mem_Wr, Done_DM, stall_pipe}, MMEM_err, MEM_readData,
                             {(k == 0) & r, (k == 0) & w, fin, !fin}, terr, trd);
                end
                if (!fin) exp_stalls++;
                tick();
                if (fin) break;
                k++;
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_hit_load();
        test_miss_store();
        test_stall_then_hit();
        test_misaligned_illegal();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
